ram_fifo_ctrl: RTL

- Pointer/flag controller that turns the single-clock simple dual-port RAM (1-cycle registered read, write on wr_req) into a first-word-fall-through FIFO.
- Drives the RAM's wr_req/wr_addr/wr_data/rd_addr and consumes its rd_data.
- Presents a valid/ready push side and a show-ahead pop side.
- Used between the SD sector reader and downstream byte consumers. The RAM is instantiated externally, next to this block.

---
 rtl/ram_fifo_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: pointer/flag controller that turns an external single-clock
// simple dual-port RAM (write on wr_req, 1-cycle registered read) into a
// first-word-fall-through FIFO with a valid/ready push side and a show-ahead
// pop side.
//
// Optional feature: define RAM_FIFO_CTRL_STATS_EN to add the hwm (high-water
// mark) and drop_cnt (saturating dropped-push counter) output ports.
//
// Pointers are ADDR_LEN+1 bits wide. The extra MSB tells a full FIFO apart
// from an empty one. Only the low ADDR_LEN bits address the RAM.
//
// NOTE: the RAM array lives outside this block and is never reset. Stale
// words cannot leak out, because o_en stays low until a freshly written word
// has had a full cycle to commit.
module ram_fifo_ctrl #(
  parameter int ADDR_LEN = 12,
  parameter int DATA_LEN = 8,
  parameter int AFULL_TH = (1 << ADDR_LEN) - 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  // push side
  input  logic                i_en,
  input  logic [DATA_LEN-1:0] i_data,
  output logic                i_rdy,
  // pop side (show-ahead)
  output logic                o_en,
  input  logic                o_rdy,
  output logic [DATA_LEN-1:0] o_data,
  // status
  output logic [ADDR_LEN:0]   count,
  output logic                almost_full,
  output logic                overflow,
`ifdef RAM_FIFO_CTRL_STATS_EN
  output logic [ADDR_LEN:0]   hwm,
  output logic [15:0]         drop_cnt,
`endif
  // RAM interface
  output logic                ram_wr_req,
  output logic [ADDR_LEN-1:0] ram_wr_addr,
  output logic [DATA_LEN-1:0] ram_wr_data,
  output logic [ADDR_LEN-1:0] ram_rd_addr,
  input  logic [DATA_LEN-1:0] ram_rd_data
);

  localparam logic [ADDR_LEN:0] DEPTH     = {1'b1, {ADDR_LEN{1'b0}}};
  localparam logic [ADDR_LEN:0] PTR_ONE   = {{ADDR_LEN{1'b0}}, 1'b1};
  localparam logic [ADDR_LEN:0] AFULL_LVL = (ADDR_LEN+1)'(AFULL_TH);

  // Registered state
  logic [ADDR_LEN:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LEN:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_LEN:0] wr_vis_q, wr_vis_d;   // wr_ptr delayed one cycle
  logic [ADDR_LEN:0] count_q,  count_d;
  logic              overflow_q, overflow_d;

  // Combinational helpers
  logic [ADDR_LEN:0] fill;
  logic [ADDR_LEN:0] rd_ptr_la;            // look-ahead read pointer
  logic              full;
  logic              push;
  logic              pop;

  // full comes from the live write pointer, so i_rdy drops the cycle after
  // the last slot is taken. o_en compares against the delayed write pointer,
  // so a word becomes visible only once the RAM read has seen the committed
  // write.
  assign fill      = wr_ptr_q - rd_ptr_q;
  assign full      = (fill == DEPTH);
  assign push      = i_en && !full;
  assign o_en      = (rd_ptr_q != wr_vis_q);
  assign pop       = o_en && o_rdy;
  assign rd_ptr_la = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

  assign i_rdy       = !full;
  assign ram_wr_req  = push;
  assign ram_wr_addr = wr_ptr_q[ADDR_LEN-1:0];
  assign ram_wr_data = i_data;
  // Reading ahead of a pop keeps ram_rd_data equal to the new head one edge
  // later, so back-to-back pops need no bubble.
  assign ram_rd_addr = rd_ptr_la[ADDR_LEN-1:0];
  assign o_data      = ram_rd_data;

  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_LVL);
  assign overflow    = overflow_q;

  // Next-state logic for the pointers, occupancy and the sticky overflow flag.
  always_comb begin
    // NOTE: every _d gets a default hold value first, so no path can leave one
    // unassigned and infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_vis_d   = wr_ptr_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_la;
    end
    if (i_en && full) begin
      overflow_d = 1'b1;
    end

    // A flush overrides any push or pop issued in the same cycle.
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      wr_vis_d   = '0;
      overflow_d = 1'b0;
    end

    count_d = wr_ptr_d - rd_ptr_d;
  end

  // State registers with asynchronous flush to an empty FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_vis_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling its pre-edge
      // inputs, independent of statement order.
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_vis_q   <= wr_vis_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef RAM_FIFO_CTRL_STATS_EN
  logic [ADDR_LEN:0] hwm_q, hwm_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  // High-water mark tracks the post-edge occupancy. The drop counter
  // saturates at all-ones.
  always_comb begin
    hwm_d      = hwm_q;
    drop_cnt_d = drop_cnt_q;

    if (count_d > hwm_q) begin
      hwm_d = count_d;
    end
    if (i_en && full && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    if (clear) begin
      hwm_d      = '0;
      drop_cnt_d = '0;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hwm_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      hwm_q      <= hwm_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign hwm      = hwm_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
